// File: rtl/decode_pkg.sv
// Shared opcode, class and state definitions for the instruction-decode stage.
// The bundle struct describes the default 32-bit configuration layout.
package decode_pkg;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_JI  = 2'd2,
        CLS_JII = 2'd3
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_JR   = 5'b00100;

    localparam logic [4:0] REG_RA     = 5'd31;
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef struct packed {
        logic [4:0]   opcode;
        logic [4:0]   rd;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   shamt;
        logic [4:0]   alu_op;
        logic [31:0]  imm;
        logic [31:0]  target;
        instr_class_e cls;
        logic         wen;
        logic [4:0]   dest;
    } decode_bundle_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction splitter: field extraction, immediate/target
// extension, instruction classification and destination-register resolution.
module decode_fields
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int ALUOP_W = 5
) (
    input  logic [DATA_W-1:0]  instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [SHAMT_W-1:0] shamt,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [DATA_W-1:0]  imm,
    output logic [DATA_W-1:0]  target,
    output logic [1:0]         cls,
    output logic               wen,
    output logic [REG_W-1:0]   dest
);

    localparam int IMM_W   = DATA_W - OPC_W - 2*REG_W;
    localparam int TGT_W   = DATA_W - OPC_W;
    localparam int RD_LSB  = DATA_W - OPC_W - REG_W;
    localparam int RS_LSB  = RD_LSB - REG_W;
    localparam int RT_LSB  = RS_LSB - REG_W;
    localparam int SH_LSB  = RT_LSB - SHAMT_W;
    localparam int ALU_LSB = SH_LSB - ALUOP_W;

    assign opcode = instr[DATA_W-1 -: OPC_W];
    assign rd     = instr[RD_LSB +: REG_W];
    assign rs     = instr[RS_LSB +: REG_W];
    assign rt     = instr[RT_LSB +: REG_W];
    assign shamt  = instr[SH_LSB +: SHAMT_W];
    assign alu_op = instr[ALU_LSB +: ALUOP_W];
    assign imm    = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign target = {{(DATA_W-TGT_W){1'b0}}, instr[TGT_W-1:0]};

    // Unknown opcodes fall through as class R with no register write (nop).
    always_comb begin
        cls  = CLS_R;
        wen  = 1'b0;
        dest = '0;
        case (opcode)
            OPC_W'(OP_ALU):  begin cls = CLS_R;   wen = 1'b1; dest = rd; end
            OPC_W'(OP_ADDI): begin cls = CLS_I;   wen = 1'b1; dest = rd; end
            OPC_W'(OP_LW):   begin cls = CLS_I;   wen = 1'b1; dest = rd; end
            OPC_W'(OP_SW):   cls = CLS_I;
            OPC_W'(OP_BNE):  cls = CLS_I;
            OPC_W'(OP_BLT):  cls = CLS_I;
            OPC_W'(OP_J):    cls = CLS_JI;
            OPC_W'(OP_BEX):  cls = CLS_JI;
            OPC_W'(OP_JAL):  begin cls = CLS_JI;  wen = 1'b1; dest = REG_W'(REG_RA); end
            OPC_W'(OP_SETX): begin cls = CLS_JI;  wen = 1'b1; dest = REG_W'(REG_STATUS); end
            OPC_W'(OP_JR):   cls = CLS_JII;
            default:         ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoded bundles pass through a two-entry skid buffer
// (output register plus skid register) with valid/ready on both sides and flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int ALUOP_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_target,
    output logic [1:0]         out_class,
    output logic               out_wen,
    output logic [REG_W-1:0]   out_dest
);

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [SHAMT_W-1:0] shamt;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  target;
        logic [1:0]         cls;
        logic               wen;
        logic [REG_W-1:0]   dest;
    } bundle_t;

    bundle_t     dec_bundle;
    bundle_t     out_bundle_q, out_bundle_d;
    bundle_t     skid_bundle_q, skid_bundle_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept, drain;
    skid_state_e state;

    decode_fields #(
        .DATA_W  (DATA_W),
        .OPC_W   (OPC_W),
        .REG_W   (REG_W),
        .SHAMT_W (SHAMT_W),
        .ALUOP_W (ALUOP_W)
    ) u_fields (
        .instr  (in_instr),
        .opcode (dec_bundle.opcode),
        .rd     (dec_bundle.rd),
        .rs     (dec_bundle.rs),
        .rt     (dec_bundle.rt),
        .shamt  (dec_bundle.shamt),
        .alu_op (dec_bundle.alu_op),
        .imm    (dec_bundle.imm),
        .target (dec_bundle.target),
        .cls    (dec_bundle.cls),
        .wen    (dec_bundle.wen),
        .dest   (dec_bundle.dest)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;
    assign state  = !out_valid_q ? ST_EMPTY : (skid_valid_q ? ST_TWO : ST_ONE);

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        out_bundle_d  = out_bundle_q;
        skid_bundle_d = skid_bundle_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_valid_d  = 1'b1;
                        out_bundle_d = dec_bundle;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_valid_d  = 1'b1;
                        skid_bundle_d = dec_bundle;
                    end else if (accept && drain) begin
                        out_bundle_d = dec_bundle;
                    end else if (drain) begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can move data.
                    if (drain) begin
                        out_bundle_d = skid_bundle_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            out_bundle_q  <= '0;
            skid_bundle_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            in_ready_q    <= in_ready_d;
            out_bundle_q  <= out_bundle_d;
            skid_bundle_q <= skid_bundle_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_opcode = out_bundle_q.opcode;
    assign out_rd     = out_bundle_q.rd;
    assign out_rs     = out_bundle_q.rs;
    assign out_rt     = out_bundle_q.rt;
    assign out_shamt  = out_bundle_q.shamt;
    assign out_alu_op = out_bundle_q.alu_op;
    assign out_imm    = out_bundle_q.imm;
    assign out_target = out_bundle_q.target;
    assign out_class  = out_bundle_q.cls;
    assign out_wen    = out_bundle_q.wen;
    assign out_dest   = out_bundle_q.dest;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: field decode, classification, skid
// buffer throughput/back-pressure, flush, reset, and a 64-bit parameter set.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_opcode, out_rd, out_rs, out_rt, out_shamt, out_alu_op, out_dest;
    logic [31:0] out_imm, out_target;
    logic [1:0]  out_class;
    logic        out_wen;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [63:0] in_instr64 = '0;
    logic        out_valid64;
    logic        out_ready64 = 1'b1;
    logic [4:0]  out_opcode64, out_shamt64, out_alu_op64;
    logic [5:0]  out_rd64, out_rs64, out_rt64, out_dest64;
    logic [63:0] out_imm64, out_target64;
    logic [1:0]  out_class64;
    logic        out_wen64;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_stage u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_target(out_target), .out_class(out_class), .out_wen(out_wen),
        .out_dest(out_dest)
    );

    decode_stage #(.DATA_W(64), .REG_W(6)) u_dut64 (
        .clock(clock), .reset(reset), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs(out_rs64), .out_rt(out_rt64),
        .out_shamt(out_shamt64), .out_alu_op(out_alu_op64), .out_imm(out_imm64),
        .out_target(out_target64), .out_class(out_class64), .out_wen(out_wen64),
        .out_dest(out_dest64)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if ({out_opcode, out_rd, out_imm, out_target, out_class, out_wen, out_dest} !== '0) begin errors++; $display("FAIL reset_data got imm=%h tgt=%h dest=%0d want all 0", out_imm, out_target, out_dest); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00443000;
        step();
        in_valid = 1'b0;
        $display("xfer add: op=%0d rd=%0d rs=%0d rt=%0d cls=%0d", out_opcode, out_rd, out_rs, out_rt, out_class);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
        checks++; if (out_opcode !== 5'd0) begin errors++; $display("FAIL add_opcode got %0d want 0", out_opcode); end
        checks++; if ({out_rd, out_rs, out_rt} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs got %0d/%0d/%0d want 1/2/3", out_rd, out_rs, out_rt); end
        checks++; if ({out_class, out_wen, out_dest} !== {2'd0, 1'b1, 5'd1}) begin errors++; $display("FAIL add_class got cls=%0d wen=%0b dest=%0d want 0/1/1", out_class, out_wen, out_dest); end

        in_valid = 1'b1; in_instr = 32'h2947FFFF;
        step();
        in_valid = 1'b0;
        $display("xfer addi: imm=%h cls=%0d dest=%0d", out_imm, out_class, out_dest);
        checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        checks++; if ({out_class, out_wen, out_dest, out_rs} !== {2'd1, 1'b1, 5'd5, 5'd3}) begin errors++; $display("FAIL addi_class got cls=%0d wen=%0b dest=%0d rs=%0d want 1/1/5/3", out_class, out_wen, out_dest, out_rs); end

        in_valid = 1'b1; in_instr = 32'h18000100;
        step();
        in_valid = 1'b0;
        $display("xfer jal: tgt=%h cls=%0d dest=%0d", out_target, out_class, out_dest);
        checks++; if (out_target !== 32'h00000100) begin errors++; $display("FAIL jal_target got %h want 00000100", out_target); end
        checks++; if ({out_class, out_wen, out_dest} !== {2'd2, 1'b1, 5'd31}) begin errors++; $display("FAIL jal_class got cls=%0d wen=%0b dest=%0d want 2/1/31", out_class, out_wen, out_dest); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0b want 0", out_valid); end
    endtask

    task automatic test_classes();
        logic [4:0] opc [9] = '{5'b00111, 5'b01000, 5'b00010, 5'b00001, 5'b10110, 5'b10101, 5'b00100, 5'b11111, 5'b00110};
        logic [1:0] cls [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
        logic       wen [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0] dst [9] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd30, 5'd0, 5'd0, 5'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_instr = {opc[i], 5'd7, 22'h0};
            step();
            in_valid = 1'b0;
            $display("xfer class op=%b: cls=%0d wen=%0b dest=%0d", opc[i], out_class, out_wen, out_dest);
            checks++; if ({out_valid, out_class, out_wen, out_dest} !== {1'b1, cls[i], wen[i], dst[i]}) begin errors++; $display("FAIL class_op%b got v=%0b cls=%0d wen=%0b dest=%0d want 1/%0d/%0b/%0d", opc[i], out_valid, out_class, out_wen, out_dest, cls[i], wen[i], dst[i]); end
        end
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_instr = {5'b00101, 5'(c + 1), 22'(c * 3)};
            end else begin
                in_valid = 1'b0;
            end
            step();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d got %0b want 1", c, in_ready); end
            if (c < 8) begin
                $display("xfer stream %0d: rd=%0d imm=%0d", c, out_rd, out_imm);
                checks++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'(c + 1), 32'(c * 3)}) begin errors++; $display("FAIL stream_data c=%0d got v=%0b rd=%0d imm=%0d want 1/%0d/%0d", c, out_valid, out_rd, out_imm, c + 1, c * 3); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", out_valid); end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = {5'b00101, 5'd11, 22'd0};
        step();
        checks++; if ({in_ready, out_valid, out_rd} !== {1'b1, 1'b1, 5'd11}) begin errors++; $display("FAIL bp_first got rdy=%0b v=%0b rd=%0d want 1/1/11", in_ready, out_valid, out_rd); end
        in_instr = {5'b00101, 5'd12, 22'd0};
        step();
        checks++; if ({in_ready, out_valid, out_rd} !== {1'b0, 1'b1, 5'd11}) begin errors++; $display("FAIL bp_second got rdy=%0b v=%0b rd=%0d want 0/1/11", in_ready, out_valid, out_rd); end
        in_instr = {5'b00101, 5'd13, 22'd0};
        step();
        checks++; if ({in_ready, out_valid, out_rd} !== {1'b0, 1'b1, 5'd11}) begin errors++; $display("FAIL bp_hold got rdy=%0b v=%0b rd=%0d want 0/1/11", in_ready, out_valid, out_rd); end
        out_ready = 1'b1;
        step();
        $display("xfer bp: rd=%0d", out_rd);
        checks++; if ({in_ready, out_valid, out_rd} !== {1'b1, 1'b1, 5'd12}) begin errors++; $display("FAIL bp_release got rdy=%0b v=%0b rd=%0d want 1/1/12", in_ready, out_valid, out_rd); end
        step();
        in_valid = 1'b0;
        $display("xfer bp: rd=%0d", out_rd);
        checks++; if ({in_ready, out_valid, out_rd} !== {1'b1, 1'b1, 5'd13}) begin errors++; $display("FAIL bp_third got rdy=%0b v=%0b rd=%0d want 1/1/13", in_ready, out_valid, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        // Flush in ONE state while a new instruction is being accepted.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = {5'b00101, 5'd21, 22'd0};
        step();
        in_instr = {5'b00101, 5'd22, 22'd0}; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_one got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
        // Flush in TWO state with in_valid high.
        in_valid = 1'b1; in_instr = {5'b00101, 5'd23, 22'd0};
        step();
        in_instr = {5'b00101, 5'd24, 22'd0};
        step();
        checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL flush_pre_two got v=%0b rdy=%0b want 1/0", out_valid, in_ready); end
        in_instr = {5'b00101, 5'd25, 22'd0}; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_two got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cyc=%0d got v=%0b rd=%0d want 0", i, out_valid, out_rd); end
        end
    endtask

    task automatic test_reset_two();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h2947FFFF;
        step();
        in_instr = 32'h18000100;
        step();
        in_instr = 32'h00443000; reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst_two_ctrl got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
        checks++; if ({out_opcode, out_rd, out_rs, out_rt, out_shamt, out_alu_op, out_imm, out_target, out_class, out_wen, out_dest} !== '0) begin errors++; $display("FAIL rst_two_data got imm=%h tgt=%h dest=%0d want all 0", out_imm, out_target, out_dest); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_two_after got %0b want 0", out_valid); end
    endtask

    task automatic test_param64();
        in_valid64 = 1'b1;
        in_instr64 = {5'b00101, 6'd37, 6'd5, 6'd40, 5'd3, 5'd7, 31'h11};
        step();
        in_valid64 = 1'b0;
        $display("xfer w64: rd=%0d rs=%0d rt=%0d imm=%h", out_rd64, out_rs64, out_rt64, out_imm64);
        checks++; if ({out_valid64, out_opcode64, out_rd64, out_rs64, out_rt64} !== {1'b1, 5'b00101, 6'd37, 6'd5, 6'd40}) begin errors++; $display("FAIL w64_fields got v=%0b op=%0d rd=%0d rs=%0d rt=%0d want 1/5/37/5/40", out_valid64, out_opcode64, out_rd64, out_rs64, out_rt64); end
        checks++; if ({out_shamt64, out_alu_op64} !== {5'd3, 5'd7}) begin errors++; $display("FAIL w64_shamt got %0d/%0d want 3/7", out_shamt64, out_alu_op64); end
        checks++; if (out_imm64 !== {17'h1FFFF, 6'd40, 5'd3, 5'd7, 31'h11}) begin errors++; $display("FAIL w64_imm got %h", out_imm64); end
        checks++; if (out_target64 !== {5'd0, 6'd37, 6'd5, 6'd40, 5'd3, 5'd7, 31'h11}) begin errors++; $display("FAIL w64_target got %h", out_target64); end
        checks++; if ({out_class64, out_wen64, out_dest64} !== {2'd1, 1'b1, 6'd37}) begin errors++; $display("FAIL w64_class got cls=%0d wen=%0b dest=%0d want 1/1/37", out_class64, out_wen64, out_dest64); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_classes();
        test_stream();
        test_back_to_back();
        test_flush();
        test_reset_two();
        test_param64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
